matmul_sequencer: RTL and testbench
===================================

Name: matmul_sequencer

Overview:
- Control FSM that sequences one matrix-multiply operation on the systolic datapath.
- Triggered by the start pulse from the APB register file (control register bit 0 write).
- Steps: clears the PE array, streams operand A/B buffer reads, waits for the skew to drain, writes result rows into the selected scratchpad target, then pulses done.
- Owns the `busy` flag that the APB slave uses to reject accesses with `pslverr`.

Parameters:
- DATA_WIDTH, 8, element width in bits.
- BUS_WIDTH, 32, APB data width; MAX_DIM = BUS_WIDTH/DATA_WIDTH (derived, 4 at default).
- SP_NTARGETS, 4, number of scratchpad result targets.
- DIM_W, 2, width of the dimension fields; encodes dim-1, so the range is 1..MAX_DIM.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request from the register file.
- cfg_n  in  DIM_W  rows of A minus 1.
- cfg_k  in  DIM_W  shared dimension minus 1.
- cfg_m  in  DIM_W  columns of B minus 1.
- cfg_target  in  $clog2(SP_NTARGETS)  scratchpad target index.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- start_err  out  1  one-cycle pulse: start arrived while busy.
- op_rd_en  out  1  read strobe to the operand A and B buffers.
- op_rd_addr  out  DIM_W  k index for the operand read.
- array_clear  out  1  zero all PE accumulators.
- array_valid  out  1  operand data on the array inputs is valid.
- col_mask  out  MAX_DIM  active result columns; bit j = (j <= cfg_m latched).
- sp_wr_en  out  1  scratchpad write strobe.
- sp_wr_addr  out  $clog2(SP_NTARGETS*MAX_DIM)  target*MAX_DIM + row.
- res_row_sel  out  DIM_W  result row muxed onto the scratchpad write data.

Behaviour:
- Reset (async, any state): state=IDLE, all counters 0, and every output 0, including col_mask.
- All outputs are registered, or decoded only from state and counter registers. There are no combinational input-to-output paths.
- States: IDLE, CLEAR, FEED, DRAIN, WRITEBACK, DONE.
- IDLE:
  - busy=0.
  - When start=1, latch cfg_* into shadow registers and go to CLEAR.
  - busy=1 from the next cycle.
- CLEAR: exactly 1 cycle; array_clear=1; then go to FEED.
- FEED:
  - Runs K = cfg_k+1 cycles with k_cnt = 0..K-1.
  - op_rd_en=1 and op_rd_addr=k_cnt.
  - Go to DRAIN after k_cnt == K-1.
- array_valid is op_rd_en delayed 1 cycle, matching the 1-cycle buffer read latency.
- DRAIN:
  - Fixed 2*MAX_DIM cycles, independent of cfg, covering array skew plus the final valid cycle.
  - Then go to WRITEBACK.
- WRITEBACK:
  - Runs N = cfg_n+1 cycles with row = 0..N-1.
  - sp_wr_en=1, res_row_sel=row, sp_wr_addr = target*MAX_DIM + row.
- DONE: 1 cycle; done=1 and busy still 1; then go to IDLE, with busy=0 next cycle.
- Total busy cycles = 1 + K + 2*MAX_DIM + N + 1; this is 18 for MAX_DIM=4, K=N=4.
- start while busy (any non-IDLE state, including DONE):
  - Ignored.
  - start_err=1 the following cycle.
  - Latched cfg is unchanged.
- start in the same cycle busy falls (first IDLE cycle) is accepted normally.
- cfg_* changes during an operation have no effect; only the shadow copies are used.
- col_mask updates on the start-accept edge and holds until the next accepted start.
- Counters never wrap past K-1 / N-1 / 2*MAX_DIM-1. An out-of-range counter value forces IDLE.
- rst asserted mid-operation:
  - Immediate IDLE with all outputs 0.
  - No done pulse and no sp_wr_en.
  - The partial scratchpad contents are left as-is.

Decomposition:
- Put in the existing matmul_pkg:
  - the state enum typedef seq_state_t;
  - constants MAX_DIM and DRAIN_CYCLES = 2*MAX_DIM;
  - the sp address-width function.
- One sub-module, matmul_seq_counter: a loadable up-counter with terminal-count flag, instantiated for the k, drain and row counts.

Test Plan:
- Reset then idle: all outputs 0; start pulse at cycle 0 with n=k=m=3, target=1 -> busy=1 from cycle 1; done at cycle 18; busy=0 at cycle 19.
- Same run, write checks: array_clear at cycle 1; op_rd_addr 0,1,2,3 in cycles 2-5; array_valid in cycles 3-6; sp_wr_addr 4,5,6,7 in cycles 14-17; col_mask=4'b1111.
- Minimal config n=k=m=0, target=3 -> one read (addr 0), one write (addr 12), col_mask=4'b0001, 12 busy cycles.
- start during FEED -> start_err pulse the next cycle; the operation completes unchanged with original cfg; no second operation.
- rst asserted during WRITEBACK after row 1 -> outputs 0 in the same cycle, no done; a new start after release runs a full normal sequence.
- Back-to-back: start in the first cycle after busy falls -> accepted; second done exactly 19 cycles after first done at default dims.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-multiply sequencer.
package matmul_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_BUS_WIDTH   = 32;
    localparam int DEF_SP_NTARGETS = 4;
    localparam int DEF_DIM_W       = 2;
    localparam int MAX_DIM         = DEF_BUS_WIDTH / DEF_DATA_WIDTH;
    localparam int DRAIN_CYCLES    = 2 * MAX_DIM;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_WRITEBACK,
        S_DONE
    } seq_state_t;

    // Scratchpad address width for ntargets blocks of max_dim rows each.
    function automatic int sp_addr_w(input int ntargets, input int max_dim);
        return (ntargets * max_dim > 1) ? $clog2(ntargets * max_dim) : 1;
    endfunction

endpackage

// File: rtl/matmul_seq_counter.sv
// Loadable up-counter that returns to zero after its terminal value.
module matmul_seq_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         tc,
    output logic         ovf
);

    assign tc  = (cnt == last);
    assign ovf = (cnt > last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Control FSM for one systolic matrix multiply: clear, feed, drain, write back, done.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int BUS_WIDTH   = DEF_BUS_WIDTH,
    parameter int SP_NTARGETS = DEF_SP_NTARGETS,
    parameter int DIM_W       = DEF_DIM_W
) (
    input  logic                                                       clk,
    input  logic                                                       rst,
    input  logic                                                       start,
    input  logic [DIM_W-1:0]                                           cfg_n,
    input  logic [DIM_W-1:0]                                           cfg_k,
    input  logic [DIM_W-1:0]                                           cfg_m,
    input  logic [$clog2(SP_NTARGETS)-1:0]                             cfg_target,
    output logic                                                       busy,
    output logic                                                       done,
    output logic                                                       start_err,
    output logic                                                       op_rd_en,
    output logic [DIM_W-1:0]                                           op_rd_addr,
    output logic                                                       array_clear,
    output logic                                                       array_valid,
    output logic [BUS_WIDTH/DATA_WIDTH-1:0]                            col_mask,
    output logic                                                       sp_wr_en,
    output logic [sp_addr_w(SP_NTARGETS, BUS_WIDTH/DATA_WIDTH)-1:0]    sp_wr_addr,
    output logic [DIM_W-1:0]                                           res_row_sel
);

    localparam int M_DIM   = BUS_WIDTH / DATA_WIDTH;
    localparam int M_DRAIN = 2 * M_DIM;
    localparam int TW      = $clog2(SP_NTARGETS);
    localparam int AW      = sp_addr_w(SP_NTARGETS, M_DIM);
    localparam int DW      = $clog2(M_DRAIN);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(M_DRAIN - 1);

    seq_state_t state, state_nxt;

    logic [DIM_W-1:0] n_q, k_q;
    logic [TW-1:0]    tgt_q;
    logic             accept;

    logic             k_en, d_en, r_en;
    logic [DIM_W-1:0] k_cnt, r_cnt;
    logic [DW-1:0]    d_cnt;
    logic             k_tc, d_tc, r_tc;
    logic             k_ovf, d_ovf, r_ovf;

    assign accept = (state == S_IDLE) && start;
    assign k_en   = (state == S_FEED);
    assign d_en   = (state == S_DRAIN);
    assign r_en   = (state == S_WRITEBACK);

    matmul_seq_counter #(.W(DIM_W)) u_k_cnt (
        .clk(clk), .rst(rst), .load(accept), .load_val('0), .en(k_en),
        .last(k_q), .cnt(k_cnt), .tc(k_tc), .ovf(k_ovf)
    );

    matmul_seq_counter #(.W(DW)) u_drain_cnt (
        .clk(clk), .rst(rst), .load(accept), .load_val('0), .en(d_en),
        .last(DRAIN_LAST), .cnt(d_cnt), .tc(d_tc), .ovf(d_ovf)
    );

    matmul_seq_counter #(.W(DIM_W)) u_row_cnt (
        .clk(clk), .rst(rst), .load(accept), .load_val('0), .en(r_en),
        .last(n_q), .cnt(r_cnt), .tc(r_tc), .ovf(r_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start) state_nxt = S_CLEAR;
            S_CLEAR:     state_nxt = S_FEED;
            S_FEED:      if (k_tc) state_nxt = S_DRAIN;
            S_DRAIN:     if (d_tc) state_nxt = S_WRITEBACK;
            S_WRITEBACK: if (r_tc) state_nxt = S_DONE;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
        // A counter beyond its terminal value means corrupted state; abandon the op.
        if (k_ovf || d_ovf || r_ovf) state_nxt = S_IDLE;
    end

    // Shadow config, column mask and registered pulses; all held stable while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q         <= '0;
            k_q         <= '0;
            tgt_q       <= '0;
            col_mask    <= '0;
            start_err   <= 1'b0;
            array_valid <= 1'b0;
        end else begin
            start_err   <= start && (state != S_IDLE);
            array_valid <= op_rd_en;
            if (accept) begin
                n_q   <= cfg_n;
                k_q   <= cfg_k;
                tgt_q <= cfg_target;
                for (int j = 0; j < M_DIM; j++) begin
                    col_mask[j] <= (j <= int'(cfg_m));
                end
            end
        end
    end

    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign array_clear = (state == S_CLEAR);
    assign op_rd_en    = k_en;
    assign op_rd_addr  = k_en ? k_cnt : '0;
    assign sp_wr_en    = r_en;
    assign res_row_sel = r_en ? r_cnt : '0;
    assign sp_wr_addr  = r_en ? (AW'(tgt_q) * AW'(M_DIM) + AW'(r_cnt)) : '0;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer with a scoreboard for operand reads and scratchpad writes.
module tb_matmul_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] cfg_n, cfg_k, cfg_m, cfg_target;
    logic       busy, done, start_err, op_rd_en, array_clear, array_valid, sp_wr_en;
    logic [1:0] op_rd_addr, res_row_sel;
    logic [3:0] col_mask, sp_wr_addr;

    int checks = 0;
    int errors = 0;
    int gcyc   = 0;

    typedef struct {
        int addr;
        int row;
    } wr_t;

    wr_t wr_q[$];
    int  rd_q[$];

    matmul_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_n(cfg_n), .cfg_k(cfg_k), .cfg_m(cfg_m), .cfg_target(cfg_target),
        .busy(busy), .done(done), .start_err(start_err),
        .op_rd_en(op_rd_en), .op_rd_addr(op_rd_addr),
        .array_clear(array_clear), .array_valid(array_valid), .col_mask(col_mask),
        .sp_wr_en(sp_wr_en), .sp_wr_addr(sp_wr_addr), .res_row_sel(res_row_sel)
    );

    always #5 clk = ~clk;
    always @(posedge clk) gcyc <= gcyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [18:0] all_out();
        return {busy, done, start_err, op_rd_en, op_rd_addr, array_clear, array_valid,
                col_mask, sp_wr_en, sp_wr_addr, res_row_sel};
    endfunction

    // Reads and writes are scored against what each op pushed when it was launched.
    always @(negedge clk) begin
        if (!rst) begin
            if (op_rd_en) begin
                if (rd_q.size() == 0) chk("rd_unexpected", 32'(op_rd_en), 32'(0));
                else begin
                    int e;
                    e = rd_q.pop_front();
                    chk("rd_addr", 32'(op_rd_addr), 32'(e));
                end
            end
            if (sp_wr_en) begin
                if (wr_q.size() == 0) chk("wr_unexpected", 32'(sp_wr_en), 32'(0));
                else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("wr_addr", 32'(sp_wr_addr), 32'(w.addr));
                    chk("wr_row", 32'(res_row_sel), 32'(w.row));
                end
            end
        end
    end

    // Launch one op in the current cycle (cycle 0) and check its timeline through the
    // first idle cycle. inj>0 pulses a conflicting start with zeroed cfg at that cycle.
    task automatic run_op(input int n, input int k, input int m, input int tgt,
                          input int inj, output int done_at);
        int kk, nn, t;
        kk = k + 1;
        nn = n + 1;
        t  = 1 + kk + 8 + nn + 1;
        done_at = -1;
        for (int i = 0; i < kk; i++) rd_q.push_back(i);
        for (int r = 0; r < nn; r++) wr_q.push_back('{tgt * 4 + r, r});
        cfg_n = 2'(n);
        cfg_k = 2'(k);
        cfg_m = 2'(m);
        cfg_target = 2'(tgt);
        start = 1'b1;
        for (int c = 1; c <= t + 1; c++) begin
            tick;
            if (c == 1) start = 1'b0;
            if (c == inj) begin
                start = 1'b1;
                cfg_n = 2'd0;
                cfg_k = 2'd0;
                cfg_m = 2'd0;
                cfg_target = 2'd0;
            end
            if (c == inj + 1) start = 1'b0;
            chk("busy", 32'(busy), 32'(c <= t));
            chk("array_clear", 32'(array_clear), 32'(c == 1));
            chk("array_valid", 32'(array_valid), 32'(c >= 3 && c <= kk + 2));
            chk("done", 32'(done), 32'(c == t));
            chk("start_err", 32'(start_err), 32'(inj > 0 && c == inj + 1));
            if (c == t) done_at = gcyc;
        end
        chk("col_mask", 32'(col_mask), 32'((1 << (m + 1)) - 1));
        chk("rd_all_seen", 32'(rd_q.size()), 32'(0));
        chk("wr_all_seen", 32'(wr_q.size()), 32'(0));
    endtask

    initial begin
        int d1, d2, dx;
        rst = 1'b1;
        start = 1'b0;
        cfg_n = '0;
        cfg_k = '0;
        cfg_m = '0;
        cfg_target = '0;
        tick;
        tick;
        chk("reset_outputs", 32'(all_out()), 32'(0));
        rst = 1'b0;
        tick;
        chk("idle_outputs", 32'(all_out()), 32'(0));

        // Default dims, then a back-to-back start in the first idle cycle.
        run_op(3, 3, 3, 1, 0, d1);
        run_op(3, 3, 3, 2, 0, d2);
        chk("b2b_done_gap", 32'(d2 - d1), 32'(19));

        // Minimal dims into the last target.
        run_op(0, 0, 0, 3, 0, dx);

        // Conflicting start during FEED; original cfg (m=2, target 2) must stand.
        run_op(3, 3, 2, 2, 3, dx);
        chk("no_second_op", 32'(busy), 32'(0));

        // Reset in WRITEBACK after rows 0 and 1 have been written.
        for (int i = 0; i < 4; i++) rd_q.push_back(i);
        wr_q.push_back('{4, 0});
        wr_q.push_back('{5, 1});
        cfg_n = 2'd3;
        cfg_k = 2'd3;
        cfg_m = 2'd3;
        cfg_target = 2'd1;
        start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick;
            if (c == 1) start = 1'b0;
        end
        chk("pre_rst_wb", 32'(sp_wr_en), 32'(1));
        rst = 1'b1;
        #1;
        chk("rst_midop_outputs", 32'(all_out()), 32'(0));
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("rst_hold_done", 32'(done), 32'(0));
            chk("rst_hold_wr", 32'(sp_wr_en), 32'(0));
        end
        rst = 1'b0;
        tick;
        chk("post_rst_idle", 32'(all_out()), 32'(0));
        chk("rst_wr_seen", 32'(wr_q.size()), 32'(0));
        chk("rst_rd_seen", 32'(rd_q.size()), 32'(0));

        run_op(3, 3, 3, 0, 0, dx);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
